pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline; sits beside the decode-stage bypass logic.
- Covers the cases forwarding cannot resolve:
  - load-use stall (bubble into D/X);
  - taken-branch/jump flush of F/D and D/X;
  - sequencing of the multi-cycle mult/div unit, freezing PC, F/D and D/X until the unit reports ready or a watchdog expires.
- Drives enables and flushes of the PC and pipeline latches, plus the start strobe of the multdiv unit.

Parameters:
- MD_TIMEOUT, 40, cycles in MD_BUSY before giving up on md_rdy.
- CNT_W, 6, width of the busy-cycle counter; must hold MD_TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- fd_instruction  in  32  instruction in F/D latch
- de_instruction  in  32  instruction in D/X latch
- branch_taken  in  1  execute stage resolved a taken branch/jump for de_instruction
- md_rdy  in  1  multdiv result valid this cycle
- pc_stall  out  1  hold PC
- fd_stall  out  1  hold F/D latch
- de_stall  out  1  hold D/X latch
- fd_flush  out  1  load nop into F/D
- de_flush  out  1  load nop into D/X
- em_bubble  out  1  load nop into X/M
- md_start  out  1  one-cycle start strobe to multdiv
- md_busy  out  1  FSM in MD_BUSY
- md_timeout  out  1  one-cycle pulse, watchdog expired

Behaviour:
- Instruction fields:
  - opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2].
  - lw = 01000.
  - mul/div = opcode 00000 with aluop 00110 or 00111.
- Sources of fd_instruction:
  - R-type: rs, rt.
  - addi, lw: rs.
  - sw, bne, blt: rd, rs.
  - jr: rd.
  - bex: r30.
  - Other opcodes read nothing.
- load_use = de is lw, de.rd != 0, and de.rd equals any fd source.
- FSM states: MD_IDLE, MD_BUSY. Counter cnt is CNT_W bits wide.
- Reset: while reset is high, state = MD_IDLE, cnt = 0, and every output is forced to 0 regardless of inputs.
- MD_IDLE:
  - If de is mul/div:
    - assert md_start;
    - assert pc_stall, fd_stall, de_stall, em_bubble;
    - next state MD_BUSY, cnt <= 0.
  - Else if branch_taken: assert fd_flush and de_flush; no stalls.
  - Else if load_use: assert pc_stall, fd_stall, de_flush.
  - Else all outputs 0.
- MD_BUSY:
  - md_busy = 1.
  - If md_rdy:
    - all stalls and em_bubble are 0 this cycle, so the result and the instruction advance into X/M;
    - next state MD_IDLE.
  - Else if cnt == MD_TIMEOUT-1:
    - md_timeout = 1;
    - stalls released exactly as for md_rdy;
    - next state MD_IDLE.
  - Else:
    - pc_stall, fd_stall, de_stall, em_bubble = 1;
    - cnt <= cnt+1.
  - md_rdy and the final timeout cycle together: md_rdy wins, md_timeout stays 0.
- md_rdy in MD_IDLE is ignored.
- md_start is never asserted in MD_BUSY.
- Back-to-back mul/div: the follower enters D/X on the release edge. The next cycle in MD_IDLE starts it again; one idle cycle between strobes is mandatory.
- Conditions are mutually exclusive by construction: de cannot be lw, mul/div and a branch simultaneously. Priority is still implemented as mul/div > branch > load_use.
- Stall outputs are combinational from state, cnt and instructions (same-cycle). State and cnt are registered.
- fd_flush and fd_stall are never both 1. Neither are de_flush and de_stall.
- Reset asserted mid-MD_BUSY: state returns to MD_IDLE on the next edge with no md_timeout pulse.

Test Plan:
- Reset: reset=1 with de=mul r3,r1,r2 → all outputs 0. Release reset → md_start=1 that cycle, state MD_BUSY next.
- Load-use: de = lw r5,0(r2); fd = add r6,r5,r7 → pc_stall=fd_stall=de_flush=1. Same with de.rd=r0, or fd = add r6,r4,r7 → all 0.
- Source decode: de = lw r5; fd = sw r5,0(r1) → stall. fd = addi r5,r1,4 (r5 is destination only) → no stall.
- Branch: branch_taken=1 with no mul/div in de → fd_flush=de_flush=1, all stalls 0.
- Multdiv normal: de = div. md_rdy asserted in the 10th MD_BUSY cycle → stalls and em_bubble=1 for start plus 9 cycles, 0 in the md_rdy cycle. md_start pulses exactly once. md_busy=1 for exactly 10 cycles.
- Multdiv timeout: md_rdy never asserted → md_timeout pulses in MD_BUSY cycle MD_TIMEOUT (cnt=39), stalls released, then MD_IDLE. Repeat with md_rdy and the timeout cycle coincident → md_timeout=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and sequencing controller for the 5-stage pipeline. It handles the
// cases that the decode-stage bypass network cannot resolve on its own:
//   - load-use hazards: hold PC and F/D, and bubble D/X;
//   - taken branches and jumps: flush F/D and D/X;
//   - multi-cycle mult/div: start the unit, then freeze PC, F/D and D/X until
//     the unit reports ready or the watchdog expires.
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-high; forces every output to 0
//   fd_instruction instruction held in the F/D latch
//   de_instruction instruction held in the D/X latch
//   branch_taken   execute stage resolved a taken branch/jump for de_instruction
//   md_rdy         multdiv result valid this cycle
//   pc_stall       hold PC
//   fd_stall       hold F/D latch
//   de_stall       hold D/X latch
//   fd_flush       load nop into F/D
//   de_flush       load nop into D/X
//   em_bubble      load nop into X/M
//   md_start       one-cycle start strobe to multdiv
//   md_busy        controller is waiting on multdiv
//   md_timeout     one-cycle pulse when the multdiv watchdog expires
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_instruction,
    input  logic [31:0] de_instruction,
    input  logic        branch_taken,
    input  logic        md_rdy,
    output logic        pc_stall,
    output logic        fd_stall,
    output logic        de_stall,
    output logic        fd_flush,
    output logic        de_flush,
    output logic        em_bubble,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_timeout
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
    localparam logic [4:0] REG_STATUS = 5'd30;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    md_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
    logic [4:0] de_op, de_rd, de_aluop;
    logic [4:0] src_a, src_b;
    logic       src_a_vld, src_b_vld;
    logic       de_is_lw, de_is_md, load_use;

    assign fd_op    = fd_instruction[31:27];
    assign fd_rd    = fd_instruction[26:22];
    assign fd_rs    = fd_instruction[21:17];
    assign fd_rt    = fd_instruction[16:12];
    assign de_op    = de_instruction[31:27];
    assign de_rd    = de_instruction[26:22];
    assign de_aluop = de_instruction[6:2];

    assign de_is_lw = (de_op == OP_LW);
    assign de_is_md = (de_op == OP_RTYPE) &&
                      ((de_aluop == ALU_MUL) || (de_aluop == ALU_DIV));

    // Work out which registers the F/D instruction reads. Stores and
    // conditional branches carry a source in the rd slot, and bex implicitly
    // reads the status register, so those need their own cases.
    always_comb begin
        src_a     = fd_rs;
        src_b     = fd_rt;
        src_a_vld = 1'b0;
        src_b_vld = 1'b0;
        case (fd_op)
            OP_RTYPE: begin
                src_a     = fd_rs;
                src_b     = fd_rt;
                src_a_vld = 1'b1;
                src_b_vld = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                src_a     = fd_rs;
                src_a_vld = 1'b1;
            end
            OP_SW, OP_BNE, OP_BLT: begin
                src_a     = fd_rd;
                src_b     = fd_rs;
                src_a_vld = 1'b1;
                src_b_vld = 1'b1;
            end
            OP_JR: begin
                src_a     = fd_rd;
                src_a_vld = 1'b1;
            end
            OP_BEX: begin
                src_a     = REG_STATUS;
                src_a_vld = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // A load into r0 never creates a dependency, since r0 reads as zero.
    assign load_use = de_is_lw && (de_rd != 5'd0) &&
                      ((src_a_vld && (src_a == de_rd)) ||
                       (src_b_vld && (src_b == de_rd)));

    // Next-state and same-cycle control outputs. Mult/div wins over a taken
    // branch, which wins over load-use. While waiting on the unit the whole
    // front end is frozen; the cycle that sees md_rdy (or the last watchdog
    // cycle) releases everything so the result and the instruction move on.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pc_stall   = 1'b0;
        fd_stall   = 1'b0;
        de_stall   = 1'b0;
        fd_flush   = 1'b0;
        de_flush   = 1'b0;
        em_bubble  = 1'b0;
        md_start   = 1'b0;
        md_busy    = 1'b0;
        md_timeout = 1'b0;
        if (reset) begin
            state_next = MD_IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (de_is_md) begin
                        md_start   = 1'b1;
                        pc_stall   = 1'b1;
                        fd_stall   = 1'b1;
                        de_stall   = 1'b1;
                        em_bubble  = 1'b1;
                        state_next = MD_BUSY;
                        cnt_next   = '0;
                    end else if (branch_taken) begin
                        fd_flush = 1'b1;
                        de_flush = 1'b1;
                    end else if (load_use) begin
                        pc_stall = 1'b1;
                        fd_stall = 1'b1;
                        de_flush = 1'b1;
                    end
                end
                MD_BUSY: begin
                    md_busy = 1'b1;
                    if (md_rdy) begin
                        state_next = MD_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        md_timeout = 1'b1;
                        state_next = MD_IDLE;
                    end else begin
                        pc_stall  = 1'b1;
                        fd_stall  = 1'b1;
                        de_stall  = 1'b1;
                        em_bubble = 1'b1;
                        cnt_next  = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = MD_IDLE;
                end
            endcase
        end
    end

    // State and busy-cycle counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl. Inputs are driven just after
// each rising edge; the expected output vector for that cycle is pushed to a
// scoreboard queue and popped and compared on the following falling edge.
// Output vector order:
//   {pc_stall, fd_stall, de_stall, fd_flush, de_flush, em_bubble,
//    md_start, md_busy, md_timeout}
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int MD_TIMEOUT = 40;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_BEX  = 5'b10110;
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam logic [8:0] V_NONE  = 9'b0;
    localparam logic [8:0] V_LU    = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [8:0] V_BR    = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [8:0] V_START = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [8:0] V_HOLD  = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [8:0] V_REL   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [8:0] V_TO    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fd_instruction = '0;
    logic [31:0] de_instruction = '0;
    logic        branch_taken = 1'b0;
    logic        md_rdy = 1'b0;
    logic        pc_stall, fd_stall, de_stall, fd_flush, de_flush;
    logic        em_bubble, md_start, md_busy, md_timeout;

    logic [8:0]  obs;
    logic [8:0]  exp_v;
    logic [8:0]  sb_q[$];
    int          errors = 0;
    int          checks = 0;

    pipeline_hazard_ctrl #(
        .MD_TIMEOUT(MD_TIMEOUT),
        .CNT_W(6)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .fd_instruction (fd_instruction),
        .de_instruction (de_instruction),
        .branch_taken   (branch_taken),
        .md_rdy         (md_rdy),
        .pc_stall       (pc_stall),
        .fd_stall       (fd_stall),
        .de_stall       (de_stall),
        .fd_flush       (fd_flush),
        .de_flush       (de_flush),
        .em_bubble      (em_bubble),
        .md_start       (md_start),
        .md_busy        (md_busy),
        .md_timeout     (md_timeout)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    assign obs = {pc_stall, fd_stall, de_stall, fd_flush, de_flush,
                  em_bubble, md_start, md_busy, md_timeout};

    function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] aluop);
        return {OP_R, rd, rs, rt, 5'd0, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] i_ins(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Drive one cycle's worth of inputs just after the rising edge.
    task automatic applyStimulus(input logic rst, input logic [31:0] fd,
                                 input logic [31:0] de, input logic br,
                                 input logic rdy);
        @(posedge clock);
        #1;
        reset          = rst;
        fd_instruction = fd;
        de_instruction = de;
        branch_taken   = br;
        md_rdy         = rdy;
    endtask

    // Reset gating, release into a multdiv start, and reset in the middle of
    // a busy wait.
    task automatic test_reset();
        logic [31:0] mul_i;
        logic [31:0] add_i;
        logic        rst_t[6];
        logic        br_t[6];
        logic        rdy_t[6];
        logic [31:0] de_t[6];
        logic [8:0]  ex_t[6];
        mul_i = r_ins(5'd3, 5'd1, 5'd2, ALU_MUL);
        add_i = r_ins(5'd6, 5'd1, 5'd2, ALU_ADD);
        rst_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        br_t  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        rdy_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        de_t  = '{mul_i, mul_i, mul_i, mul_i, mul_i, add_i};
        ex_t  = '{V_NONE, V_NONE, V_START, V_HOLD, V_NONE, V_NONE};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(rst_t[i], 32'd0, de_t[i], br_t[i], rdy_t[i]);
            sb_q.push_back(ex_t[i]);
            @(negedge clock);
            exp_v = sb_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("[TB] FAIL reset cyc%0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    // Load-use detection across the source-decode classes, plus taken-branch
    // flushes and branch-over-load-use priority.
    task automatic test_load_use();
        logic [31:0] lw5;
        logic [31:0] fd_t[14];
        logic [31:0] de_t[14];
        logic        br_t[14];
        logic [8:0]  ex_t[14];
        lw5 = i_ins(OP_LW, 5'd5, 5'd2, 17'd0);
        fd_t = '{r_ins(5'd6, 5'd5, 5'd7, ALU_ADD),
                 r_ins(5'd6, 5'd7, 5'd5, ALU_ADD),
                 r_ins(5'd6, 5'd0, 5'd7, ALU_ADD),
                 r_ins(5'd6, 5'd4, 5'd7, ALU_ADD),
                 i_ins(OP_SW, 5'd5, 5'd1, 17'd0),
                 i_ins(OP_ADDI, 5'd5, 5'd1, 17'd4),
                 i_ins(OP_ADDI, 5'd6, 5'd5, 17'd4),
                 i_ins(OP_BLT, 5'd1, 5'd5, 17'd2),
                 i_ins(OP_JR, 5'd5, 5'd0, 17'd0),
                 i_ins(OP_BEX, 5'd0, 5'd0, 17'd9),
                 i_ins(OP_J, 5'd5, 5'd5, 17'd0),
                 r_ins(5'd6, 5'd5, 5'd7, ALU_ADD),
                 r_ins(5'd6, 5'd1, 5'd2, ALU_ADD),
                 r_ins(5'd6, 5'd5, 5'd7, ALU_ADD)};
        de_t = '{lw5, lw5, i_ins(OP_LW, 5'd0, 5'd2, 17'd0), lw5,
                 lw5, lw5, lw5, lw5, lw5,
                 i_ins(OP_LW, 5'd30, 5'd2, 17'd0), lw5,
                 i_ins(OP_ADDI, 5'd5, 5'd2, 17'd1),
                 r_ins(5'd8, 5'd1, 5'd2, ALU_ADD), lw5};
        br_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        ex_t = '{V_LU, V_LU, V_NONE, V_NONE, V_LU, V_NONE, V_LU,
                 V_LU, V_LU, V_LU, V_NONE, V_NONE, V_BR, V_BR};
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, fd_t[i], de_t[i], br_t[i], 1'b0);
            sb_q.push_back(ex_t[i]);
            @(negedge clock);
            exp_v = sb_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("[TB] FAIL load_use case%0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    // Normal multdiv: md_rdy in IDLE is ignored, a taken branch does not
    // override the start, and md_rdy arrives in the 10th busy cycle.
    task automatic test_multdiv_normal();
        logic [31:0] div_i;
        logic [31:0] nop_i;
        logic [8:0]  e;
        logic        br;
        logic        rdy;
        logic [31:0] de;
        div_i = r_ins(5'd4, 5'd1, 5'd2, ALU_DIV);
        nop_i = 32'd0;
        for (int c = 0; c < 13; c++) begin
            de  = (c == 0 || c == 12) ? nop_i : div_i;
            rdy = (c == 0 || c == 11);
            br  = (c == 1);
            if (c == 1)
                e = V_START;
            else if (c >= 2 && c <= 10)
                e = V_HOLD;
            else if (c == 11)
                e = V_REL;
            else
                e = V_NONE;
            applyStimulus(1'b0, nop_i, de, br, rdy);
            sb_q.push_back(e);
            @(negedge clock);
            exp_v = sb_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("[TB] FAIL md_normal cyc%0d: got %b want %b", c, obs, exp_v);
            end
        end
    endtask

    // Watchdog: without md_rdy the pulse lands in busy cycle MD_TIMEOUT; a
    // second pass makes md_rdy coincide with that cycle so it must win.
    task automatic test_multdiv_timeout();
        logic [31:0] mul_i;
        logic [8:0]  e;
        logic        rdy;
        logic [31:0] de;
        mul_i = r_ins(5'd9, 5'd1, 5'd2, ALU_MUL);
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c <= MD_TIMEOUT + 1; c++) begin
                de  = (c == MD_TIMEOUT + 1) ? 32'd0 : mul_i;
                rdy = (pass == 1) && (c == MD_TIMEOUT);
                if (c == 0)
                    e = V_START;
                else if (c < MD_TIMEOUT)
                    e = V_HOLD;
                else if (c == MD_TIMEOUT)
                    e = (pass == 0) ? V_TO : V_REL;
                else
                    e = V_NONE;
                applyStimulus(1'b0, 32'd0, de, 1'b0, rdy);
                sb_q.push_back(e);
                @(negedge clock);
                exp_v = sb_q.pop_front();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL md_timeout pass%0d cyc%0d: got %b want %b",
                             pass, c, obs, exp_v);
                end
            end
        end
    endtask

    // A follower mul/div enters D/X on the release edge and must be started
    // again on the very next (idle) cycle.
    task automatic test_back_to_back();
        logic [31:0] de_t[8];
        logic        rdy_t[8];
        logic [8:0]  ex_t[8];
        logic [31:0] m1;
        logic [31:0] m2;
        m1 = r_ins(5'd3, 5'd1, 5'd2, ALU_MUL);
        m2 = r_ins(5'd7, 5'd3, 5'd3, ALU_DIV);
        de_t  = '{m1, m1, m1, m2, m2, m2, 32'd0, 32'd0};
        rdy_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ex_t  = '{V_START, V_HOLD, V_REL, V_START, V_HOLD, V_REL, V_NONE, V_NONE};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'd0, de_t[i], 1'b0, rdy_t[i]);
            sb_q.push_back(ex_t[i]);
            @(negedge clock);
            exp_v = sb_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("[TB] FAIL back_to_back cyc%0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        test_reset();
        test_load_use();
        test_multdiv_normal();
        test_multdiv_timeout();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
